// File: rtl/sprite_pkg.sv
// Shared widths, FSM encoding and attribute record for the sprite fetch sequencer.
package sprite_pkg;

  localparam int DIM_W  = 6;
  localparam int ANIM_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic [ANIM_W-1:0] anim_steps;
  } sprite_attr_t;

  // Steps of 0 or 1 pin the frame at 0, since frame+1 >= steps always holds.
  function automatic logic [ANIM_W-1:0] frame_next(input logic [ANIM_W-1:0] frame,
                                                   input logic [ANIM_W-1:0] steps);
    logic [ANIM_W:0] inc;
    inc = {1'b0, frame} + (ANIM_W+1)'(1);
    if (inc >= {1'b0, steps}) return '0;
    return inc[ANIM_W-1:0];
  endfunction

endpackage

// File: rtl/sprite_fetch_seq_if.sv
// Attribute-bus and pixel-address handshake bundle of sprite_fetch_seq.
// The hflip signal exists only when SPRITE_HFLIP_EN is defined.
interface sprite_fetch_seq_if #(parameter int ADDR_W = 15);
  import sprite_pkg::*;

  logic              start;
  logic              attr_oe;
  logic [DIM_W-1:0]  bus_width;
  logic [DIM_W-1:0]  bus_height;
  logic [ANIM_W-1:0] bus_anim_steps;
  logic              frame_tick;
  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W-1:0] pix_addr;
  logic [DIM_W-1:0]  pix_x;
  logic [DIM_W-1:0]  pix_y;
  logic              busy;
  logic              done;
`ifdef SPRITE_HFLIP_EN
  logic              hflip;
`endif

  modport master (
`ifdef SPRITE_HFLIP_EN
    output hflip,
`endif
    output start, bus_width, bus_height, bus_anim_steps, frame_tick, pix_ready,
    input  attr_oe, pix_valid, pix_addr, pix_x, pix_y, busy, done
  );

  modport slave (
`ifdef SPRITE_HFLIP_EN
    input  hflip,
`endif
    input  start, bus_width, bus_height, bus_anim_steps, frame_tick, pix_ready,
    output attr_oe, pix_valid, pix_addr, pix_x, pix_y, busy, done
  );

endinterface

// File: rtl/sprite_anim_counter.sv
// Animation frame counter: immediate update in IDLE, one collapsed pending tick applied at DONE.
module sprite_anim_counter
  import sprite_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_tick,
  input  logic              i_idle,
  input  logic              i_apply,
  input  logic [ANIM_W-1:0] i_anim_steps,
  output logic [ANIM_W-1:0] o_frame
);

  logic [ANIM_W-1:0] r_frame;
  logic              r_pending;

  // NOTE: sequential state uses <= so every register sees pre-edge values of its peers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame   <= '0;
      r_pending <= 1'b0;
    end else if (i_idle) begin
      if (i_tick) r_frame <= frame_next(r_frame, i_anim_steps);
    end else if (i_apply) begin
      // A tick landing in the DONE cycle itself merges with any pending one.
      if (r_pending || i_tick) r_frame <= frame_next(r_frame, i_anim_steps);
      r_pending <= 1'b0;
    end else if (i_tick) begin
      r_pending <= 1'b1;
    end
  end

  assign o_frame = r_frame;

endmodule

// File: rtl/sprite_fetch_seq.sv
// Sprite pixel-address sequencer: latches attributes, then scans width x height addresses.
// Optional horizontal mirroring of pix_addr is built when SPRITE_HFLIP_EN is defined.
module sprite_fetch_seq
  import sprite_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic               clock,
  input  logic               reset,
  sprite_fetch_seq_if.slave  bus
);

  state_t            r_state, w_next;
  sprite_attr_t      r_attr, w_bus_attr;
  logic [DIM_W-1:0]  r_x, r_y;
  logic [ADDR_W-1:0] r_row_base, w_addr;
  logic [ANIM_W-1:0] w_frame;
  logic              w_xfer, w_last_col, w_last_row;
  logic              w_attr_oe, w_valid, w_busy, w_done;
`ifdef SPRITE_HFLIP_EN
  logic              r_hflip;
`endif

  assign w_bus_attr = '{width: bus.bus_width, height: bus.bus_height,
                        anim_steps: bus.bus_anim_steps};
  assign w_xfer     = (r_state == ST_SCAN) && bus.pix_ready;
  assign w_last_col = (r_x == r_attr.width - DIM_W'(1));
  assign w_last_row = (r_y == r_attr.height - DIM_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    w_next    = r_state;
    w_attr_oe = 1'b0;
    w_valid   = 1'b0;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = ST_LATCH;
      end
      ST_LATCH: begin
        w_attr_oe = 1'b1;
        if (bus.bus_width == '0 || bus.bus_height == '0) w_next = ST_DONE;
        else                                              w_next = ST_SCAN;
      end
      ST_SCAN: begin
        w_valid = 1'b1;
        if (w_xfer && w_last_col && w_last_row) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Scan origin is computed from the bus values being latched on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_attr     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
`ifdef SPRITE_HFLIP_EN
      r_hflip    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_LATCH: begin
          r_attr     <= w_bus_attr;
          r_x        <= '0;
          r_y        <= '0;
          r_row_base <= ADDR_W'(w_frame) * ADDR_W'(bus.bus_width) * ADDR_W'(bus.bus_height);
`ifdef SPRITE_HFLIP_EN
          r_hflip    <= bus.hflip;
`endif
        end
        ST_SCAN: begin
          if (w_xfer) begin
            if (w_last_col) begin
              r_x        <= '0;
              r_y        <= r_y + DIM_W'(1);
              r_row_base <= r_row_base + ADDR_W'(r_attr.width);
            end else begin
              r_x <= r_x + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPRITE_HFLIP_EN
  assign w_addr = r_hflip ? r_row_base + ADDR_W'(r_attr.width - DIM_W'(1) - r_x)
                          : r_row_base + ADDR_W'(r_x);
`else
  assign w_addr = r_row_base + ADDR_W'(r_x);
`endif

  sprite_anim_counter u_anim (
    .clock        (clock),
    .reset        (reset),
    .i_tick       (bus.frame_tick),
    .i_idle       (r_state == ST_IDLE),
    .i_apply      (r_state == ST_DONE),
    .i_anim_steps (r_attr.anim_steps),
    .o_frame      (w_frame)
  );

  assign bus.attr_oe   = w_attr_oe;
  assign bus.pix_valid = w_valid;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.pix_addr  = w_valid ? w_addr : '0;
  assign bus.pix_x     = w_valid ? r_x    : '0;
  assign bus.pix_y     = w_valid ? r_y    : '0;

endmodule

// File: tb/tb_sprite_fetch_seq.sv
// Directed bench for sprite_fetch_seq: scans, backpressure, animation, zero size, abort.
module tb_sprite_fetch_seq;
  import sprite_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  sprite_fetch_seq_if #(.ADDR_W(15)) bus ();

  sprite_fetch_seq #(.ADDR_W(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_frame();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".attr_oe"},   bus.attr_oe,   0);
    check({tag, ".pix_valid"}, bus.pix_valid, 0);
    check({tag, ".done"},      bus.done,      0);
    check({tag, ".busy"},      bus.busy,      0);
    check({tag, ".pix_addr"},  bus.pix_addr,  0);
    check({tag, ".pix_x"},     bus.pix_x,     0);
    check({tag, ".pix_y"},     bus.pix_y,     0);
  endtask

  // Runs one scan; stalls pix_ready for stall_len cycles at transfer index stall_at.
  task automatic do_scan(input string tag, input int w, input int h, input int s,
                         input int base, input int stall_at, input int stall_len,
                         input bit mid_ticks);
    int got, cyc, stalls, oe_cnt, done_cyc, scan_cyc;
    got = 0; cyc = 0; stalls = 0; oe_cnt = 0; done_cyc = -1; scan_cyc = 0;
    bus.bus_width      = 6'(w);
    bus.bus_height     = 6'(h);
    bus.bus_anim_steps = 3'(s);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (done_cyc < 0 && cyc < 300) begin
      bus.frame_tick = 1'b0;
      if (bus.attr_oe) oe_cnt++;
      if (bus.pix_valid) begin
        check({tag, ".addr"}, bus.pix_addr, base + got);
        check({tag, ".x"},    bus.pix_x,    got % w);
        check({tag, ".y"},    bus.pix_y,    got / w);
        if (mid_ticks && (scan_cyc == 0 || scan_cyc == 2)) bus.frame_tick = 1'b1;
        scan_cyc++;
        if (got == stall_at && stalls < stall_len) begin
          bus.pix_ready = 1'b0;
          stalls++;
        end else begin
          bus.pix_ready = 1'b1;
          got++;
        end
      end else begin
        bus.pix_ready = 1'b1;
      end
      if (bus.done) begin
        done_cyc  = cyc;
        bus.start = 1'b1;
      end
      step();
      cyc++;
    end
    bus.start      = 1'b0;
    bus.frame_tick = 1'b0;
    bus.pix_ready  = 1'b1;
    check({tag, ".done_latency"}, done_cyc, 1 + w * h + stall_len);
    check({tag, ".transfers"},    got,      w * h);
    check({tag, ".scan_cycles"},  scan_cyc, w * h + stall_len);
    check({tag, ".attr_oe_cnt"},  oe_cnt,   1);
    check({tag, ".done_pulse"},   bus.done, 0);
    check({tag, ".start_in_done_ignored"}, bus.busy, 0);
  endtask

  initial begin
    reset              = 1'b1;
    bus.start          = 1'b0;
    bus.frame_tick     = 1'b0;
    bus.pix_ready      = 1'b1;
    bus.bus_width      = '0;
    bus.bus_height     = '0;
    bus.bus_anim_steps = '0;
`ifdef SPRITE_HFLIP_EN
    bus.hflip          = 1'b0;
`endif
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    do_scan("scan3x2", 3, 2, 1, 0, -1, 0, 1'b0);
    tick_frame();
    do_scan("backpressure", 4, 1, 1, 0, 2, 3, 1'b0);

    do_scan("anim_f0", 2, 2, 3, 0, -1, 0, 1'b0);
    tick_frame();
    do_scan("anim_f1", 2, 2, 3, 4, -1, 0, 1'b0);
    tick_frame();
    do_scan("anim_f2", 2, 2, 3, 8, -1, 0, 1'b0);
    tick_frame();
    do_scan("anim_wrap", 2, 2, 3, 0, -1, 0, 1'b0);

    do_scan("midtick", 2, 2, 3, 0, -1, 0, 1'b1);
    do_scan("midtick_after", 2, 2, 3, 4, -1, 0, 1'b0);

    do_scan("zero_size", 0, 5, 3, 0, -1, 0, 1'b0);

    // Frame is 1 here, so the aborted scan starts at 1*3*2 = 6.
    bus.bus_width      = 6'd3;
    bus.bus_height     = 6'd2;
    bus.bus_anim_steps = 3'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      check("abort.pre_addr", bus.pix_addr, 6 + i);
      step();
    end
    check("abort.third_addr", bus.pix_addr, 8);
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    step();
    reset = 1'b0;
    step();
    check("abort.no_done", bus.done, 0);
    check("abort.idle", bus.busy, 0);
    do_scan("post_abort", 3, 2, 3, 0, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
